// File: rtl/cuentas_pkg.sv
// ============================================================================
// cuentas_pkg -- shared types and destination codes for the count demux.
// Rev 1.0
// ============================================================================
`default_nettype none

package cuentas_pkg;

  localparam int SEL_W     = 2;
  localparam int N_CUENTAS = 4;

  localparam logic [SEL_W-1:0] SEL_D0 = 2'd0;
  localparam logic [SEL_W-1:0] SEL_D1 = 2'd1;
  localparam logic [SEL_W-1:0] SEL_D2 = 2'd2;
  localparam logic [SEL_W-1:0] SEL_D3 = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    COMMIT = 2'd3
  } state_t;

  function automatic logic [N_CUENTAS-1:0] decode_sel(input logic [SEL_W-1:0] s);
    logic [N_CUENTAS-1:0] oh;
    oh = '0;
    case (s)
      SEL_D0:  oh = 4'b0001;
      SEL_D1:  oh = 4'b0010;
      SEL_D2:  oh = 4'b0100;
      SEL_D3:  oh = 4'b1000;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_desplazamiento.sv
// ============================================================================
// reg_desplazamiento -- WIDTH-bit serial-in shift register, MSB first, with
// enable and sync clear. PARITY_CHECK_EN adds an even-parity accumulator.
// Rev 1.0
// ============================================================================
`default_nettype none

module reg_desplazamiento #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
`ifdef PARITY_CHECK_EN
  output logic             par,
`endif
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (clr)     sr_d = '0;
    else if (en) sr_d = {sr_q[WIDTH-2:0], din};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr_q <= '0;
    else        sr_q <= sr_d;
  end

  assign q = sr_q;

`ifdef PARITY_CHECK_EN
  logic par_q, par_d;

  always_comb begin
    par_d = par_q;
    if (clr)     par_d = 1'b0;
    else if (en) par_d = par_q ^ din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_q <= 1'b0;
    else        par_q <= par_d;
  end

  assign par = par_q;
`endif

endmodule

`default_nettype wire

// File: rtl/demux_cuentas.sv
// ============================================================================
// demux_cuentas -- serial-to-parallel 1:4 count distributor.
// Optional even-parity frame check enabled by defining PARITY_CHECK_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module demux_cuentas
  import cuentas_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inicio,
  input  logic [SEL_W-1:0] seleccion,
  input  logic             dato_in,
  input  logic             valido_in,
  output logic [WIDTH-1:0] D0,
  output logic [WIDTH-1:0] D1,
  output logic [WIDTH-1:0] D2,
  output logic [WIDTH-1:0] D3,
  output logic             ocupado,
  output logic             listo,
  output logic             error
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             ocupado_q, listo_q, listo_d;
  logic             error_d;
  logic             sr_clr, sr_en;
  logic [WIDTH-1:0] sr;
  logic [N_CUENTAS-1:0] we;
  logic [WIDTH-1:0] cuenta_q [N_CUENTAS];

`ifdef PARITY_CHECK_EN
  logic par;
  logic error_q;
`endif

  reg_desplazamiento #(.WIDTH(WIDTH)) u_sr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (sr_clr),
    .en    (sr_en),
    .din   (dato_in),
`ifdef PARITY_CHECK_EN
    .par   (par),
`endif
    .q     (sr)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    listo_d = 1'b0;
    error_d = 1'b0;
    sr_clr  = 1'b0;
    sr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (inicio) begin
          sel_d   = seleccion;
          cnt_d   = '0;
          sr_clr  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (valido_in) begin
          sr_en = 1'b1;
          if (cnt_q == CNT_LAST) begin
`ifdef PARITY_CHECK_EN
            state_d = PARITY;
`else
            state_d = COMMIT;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
`ifdef PARITY_CHECK_EN
      PARITY: begin
        if (valido_in) begin
          // Even parity: the extra bit must equal the XOR of the data bits.
          if (dato_in == par) begin
            state_d = COMMIT;
          end else begin
            error_d = 1'b1;
            state_d = IDLE;
          end
        end
      end
`endif
      COMMIT: begin
        listo_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sel_q     <= '0;
      ocupado_q <= 1'b0;
      listo_q   <= 1'b0;
`ifdef PARITY_CHECK_EN
      error_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      ocupado_q <= (state_d != IDLE);
      listo_q   <= listo_d;
`ifdef PARITY_CHECK_EN
      error_q   <= error_d;
`endif
    end
  end

  assign we = (state_q == COMMIT) ? decode_sel(sel_q) : '0;

  for (genvar i = 0; i < N_CUENTAS; i++) begin : g_cuentas
    logic [WIDTH-1:0] cuenta_d;

    always_comb begin
      cuenta_d = cuenta_q[i];
      if (we[i]) cuenta_d = sr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cuenta_q[i] <= '0;
      else        cuenta_q[i] <= cuenta_d;
    end
  end

  assign D0      = cuenta_q[0];
  assign D1      = cuenta_q[1];
  assign D2      = cuenta_q[2];
  assign D3      = cuenta_q[3];
  assign ocupado = ocupado_q;
  assign listo   = listo_q;

`ifdef PARITY_CHECK_EN
  assign error = error_q;
`else
  logic unused_ok;
  assign unused_ok = error_d;
  assign error = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_demux_cuentas.sv
// ============================================================================
// tb_demux_cuentas -- scoreboard bench: driver pushes expected commits, the
// monitor pops and compares them whenever listo/error is presented.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_demux_cuentas;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         inicio = 1'b0;
  logic [1:0]   seleccion = 2'd0;
  logic         dato_in = 1'b0;
  logic         valido_in = 1'b0;
  logic [W-1:0] D0, D1, D2, D3;
  logic         ocupado, listo, error;

  demux_cuentas #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .inicio    (inicio),
    .seleccion (seleccion),
    .dato_in   (dato_in),
    .valido_in (valido_in),
    .D0        (D0),
    .D1        (D1),
    .D2        (D2),
    .D3        (D3),
    .ocupado   (ocupado),
    .listo     (listo),
    .error     (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sel;
    int val;
    int cyc;
    bit is_err;
  } exp_t;

  exp_t q[$];
  int   mem [4];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: reference register file updated only by popped expectations.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) mem[i] = 0;
      q.delete();
      check("rst_D", int'({D0, D1, D2, D3}), 0);
      check("rst_ocupado", int'(ocupado), 0);
      check("rst_listo", int'(listo), 0);
      check("rst_error", int'(error), 0);
    end else if (listo || error) begin
      if (q.size() == 0) begin
        check("spurious_pulse", int'({listo, error}), 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("latency", cyc, e.cyc);
        check("error_kind", int'(error), int'(e.is_err));
        check("listo_kind", int'(listo), int'(!e.is_err));
        if (!e.is_err) mem[e.sel] = e.val;
        check("D0", int'(D0), mem[0]);
        check("D1", int'(D1), mem[1]);
        check("D2", int'(D2), mem[2]);
        check("D3", int'(D3), mem[3]);
      end
    end else if (q.size() > 0 && q[0].cyc < cyc) begin
      check("missing_pulse", cyc, q[0].cyc);
      void'(q.pop_front());
    end
  end

  task automatic drive(input int ini, input int s, input int v, input int d);
    @(posedge clk);
    #1;
    inicio    = ini[0];
    seleccion = s[1:0];
    valido_in = v[0];
    dato_in   = d[0];
  endtask

  task automatic idle(input int n, input bit noise);
    repeat (n) drive(0, $urandom, noise ? int'($urandom % 2) : 0, $urandom);
  endtask

  // One frame: inicio (with a random, ignored data strobe), MSB-first bits with
  // random stalls, optional parity bit, then the commit cycle.
  task automatic send_frame(input int sel, input int val, input int maxgap,
                            input bit spurious, input bit bad_par);
    exp_t e;
    int   p;
    drive(1, sel, $urandom % 2, $urandom);
    for (int i = W - 1; i >= 0; i--) begin
      int gaps;
      gaps = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      repeat (gaps) begin
        drive(spurious ? int'($urandom % 2) : 0, $urandom, 0, $urandom);
        @(negedge clk);
        check("ocupado_stall", int'(ocupado), 1);
      end
      drive((spurious && i == W - 2) ? 1 : 0, spurious ? 3 : int'($urandom),
            1, (val >> i) & 1);
      @(negedge clk);
      check("ocupado_bit", int'(ocupado), 1);
    end
`ifdef PARITY_CHECK_EN
    p = 0;
    for (int i = 0; i < W; i++) p ^= (val >> i) & 1;
    drive(0, $urandom, 1, p ^ int'(bad_par));
    e.cyc = bad_par ? cyc + 1 : cyc + 2;
`else
    p = 0;
    e.cyc = cyc + 2;
`endif
    e.sel    = sel;
    e.val    = val & ((1 << W) - 1);
    e.is_err = bad_par;
    q.push_back(e);
    drive(0, $urandom, 0, $urandom + p);
  endtask

  initial begin
    // Reset held with random inputs.
    repeat (4) begin
      @(posedge clk);
      #1;
      inicio    = 1'($urandom);
      seleccion = 2'($urandom);
      valido_in = 1'($urandom);
      dato_in   = 1'($urandom);
    end
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    inicio = 1'b0;
    idle(3, 1'b1);
    @(negedge clk);
    check("post_rst_D", int'({D0, D1, D2, D3}), 0);
    check("post_rst_ocupado", int'(ocupado), 0);

    // Basic write: 1,0,1,1 -> D2.
    send_frame(2, 'hB, 0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("basic_D2", int'(D2), 'hB);
    check("basic_others", int'({D0, D1, D3}), 0);
    idle(2, 1'b1);

    // Stalls: 0,1,1,0 -> D1.
    send_frame(1, 'h6, 3, 1'b0, 1'b0);
    idle(3, 1'b0);
    @(negedge clk);
    check("stall_D1", int'(D1), 'h6);

    // All destinations back to back.
    send_frame(0, 'h1, 0, 1'b0, 1'b0);
    send_frame(1, 'h2, 0, 1'b0, 1'b0);
    send_frame(2, 'h4, 0, 1'b0, 1'b0);
    send_frame(3, 'h8, 0, 1'b0, 1'b0);
    idle(2, 1'b0);
    @(negedge clk);
    check("b2b_D", int'({D0, D1, D2, D3}), 'h1248);

    // inicio with seleccion=11 during 2nd bit of a D0 frame is ignored.
    send_frame(0, 'hA, 1, 1'b1, 1'b0);
    idle(3, 1'b0);
    @(negedge clk);
    check("restart_D0", int'(D0), 'hA);
    check("restart_D3", int'(D3), 'h8);

    // Abort mid-frame with a reset pulse.
    drive(1, 3, 0, 0);
    drive(0, 0, 1, 1);
    drive(0, 0, 1, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(0, 0, 1, 1);
    idle(4, 1'b1);
    @(negedge clk);
    check("abort_D", int'({D0, D1, D2, D3}), 0);

`ifdef PARITY_CHECK_EN
    send_frame(2, 'hB, 0, 1'b0, 1'b0);
    send_frame(2, 'hB, 0, 1'b0, 1'b1);
    send_frame(1, 'h5, 2, 1'b0, 1'b1);
    idle(3, 1'b0);
`endif

    // Randomized frames with idle noise between them.
    for (int k = 0; k < 24; k++) begin
      bit bp;
`ifdef PARITY_CHECK_EN
      bp = ($urandom % 4) == 0;
`else
      bp = 1'b0;
`endif
      send_frame($urandom % 4, $urandom % 16, $urandom % 4,
                 1'($urandom % 3 == 0), bp);
      idle($urandom % 3, 1'b1);
    end

    // Bounded drain of outstanding expectations.
    for (int t = 0; t < 20 && q.size() > 0; t++) @(posedge clk);
    @(negedge clk);
    check("drain", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
